// File: rtl/mul_share_arbiter.sv
// Shares one multi-cycle multiplier between two requesters, round-robin on contention.
// gnt one cycle after req seen in IDLE; vld one cycle after mul_done or after a watchdog timeout.
module mul_share_arbiter #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic [DW-1:0]   a0,
    input  logic [DW-1:0]   b0,
    input  logic            req1,
    input  logic [DW-1:0]   a1,
    input  logic [DW-1:0]   b1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            vld0,
    output logic            vld1,
    output logic [2*DW-1:0] res,
    output logic            err,
    output logic            mul_start,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    input  logic            mul_done,
    input  logic [2*DW-1:0] mul_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [TW-1:0]     wdog_q;
    logic              last_q;
    logic              owner_q;
    logic              gnt0_q, gnt1_q, vld0_q, vld1_q, err_q, start_q;
    logic [2*DW-1:0]   res_q;
    logic [DW-1:0]     mul_a_q, mul_b_q;

    logic              sel1_d;
    logic [TW-1:0]     wdog_d;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    always_comb begin
        sel1_d = req1 & (~req0 | ~last_q);
        wdog_d = wdog_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wdog_q  <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            res_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        owner_q <= sel1_d;
                        gnt0_q  <= ~sel1_d;
                        gnt1_q  <= sel1_d;
                        start_q <= 1'b1;
                        mul_a_q <= sel1_d ? a1 : a0;
                        mul_b_q <= sel1_d ? b1 : b0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wdog_q <= wdog_d;
                    // A done pulse in the final watchdog cycle still counts as success.
                    if (mul_done) begin
                        res_q   <= mul_result;
                        err_q   <= 1'b0;
                        vld0_q  <= ~owner_q;
                        vld1_q  <= owner_q;
                        state_q <= RESP;
                    end else if (wdog_q == TW'(TIMEOUT - 1)) begin
                        res_q   <= '0;
                        err_q   <= 1'b1;
                        vld0_q  <= ~owner_q;
                        vld1_q  <= owner_q;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign vld0      = vld0_q;
    assign vld1      = vld1_q;
    assign res       = res_q;
    assign err       = err_q;
    assign mul_start = start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed table, contention/reset sequences, random traffic vs. a timeline model.
module tb_mul_share_arbiter;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset, req0, req1, mul_done;
    logic [DW-1:0] a0, b0, a1, b1, mul_a, mul_b;
    logic          gnt0, gnt1, vld0, vld1, err, mul_start;
    logic [31:0]   res, mul_result;

    int checks = 0;
    int errors = 0;

    mul_share_arbiter #(.DW(DW), .TIMEOUT(TO), .TW(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .vld0(vld0), .vld1(vld1),
        .res(res), .err(err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stimulus knobs for the external multiplier; the model latches them per operation.
    int lat_cfg = 3;
    bit ovr_cfg = 0;
    int lat_op  = 0;
    bit ovr_op  = 0;

    // Multiplier stand-in: done pulse lat_op cycles after start (0 = never).
    initial begin
        int          cnt;
        logic [31:0] prod;
        cnt = 0;
        prod = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_done   = 1'b0;
            mul_result = $urandom;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mul_done   = 1'b1;
                    mul_result = prod;
                end
            end
            if (mul_start === 1'b1) begin
                cnt  = lat_op;
                prod = ovr_op ? 32'h1234 : 32'(mul_a) * 32'(mul_b);
            end
        end
    end

    // Reference model: one op at a time, scheduled as cycle timestamps.
    bit            mon_en = 0;
    int            cyc = 0, gnt_cyc = -1, vld_cyc = -1, idle_from = 0;
    bit            own = 0, last_m = 1, exp_err = 0, tmo;
    logic [DW-1:0] op_a, op_b;
    logic [31:0]   exp_res;
    bit            eg0, eg1, ev0, ev1;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                eg0 = (cyc == gnt_cyc) && !own;
                eg1 = (cyc == gnt_cyc) && own;
                ev0 = (cyc == vld_cyc) && !own;
                ev1 = (cyc == vld_cyc) && own;
                chk("ctrl{g0,g1,st,v0,v1}", {gnt0, gnt1, mul_start, vld0, vld1},
                    {eg0, eg1, eg0 | eg1, ev0, ev1});
                if (cyc == gnt_cyc) chk("mul_ops", {mul_a, mul_b}, {op_a, op_b});
                if (cyc == vld_cyc) begin
                    chk("model_res", res, exp_res);
                    chk("model_err", err, exp_err);
                end
                if (reset) begin
                    gnt_cyc = -1; vld_cyc = -1; last_m = 1; idle_from = cyc + 1;
                end else if (cyc >= idle_from && (req0 || req1)) begin
                    own     = (req0 && req1) ? !last_m : req1;
                    last_m  = own;
                    op_a    = own ? a1 : a0;
                    op_b    = own ? b1 : b0;
                    lat_op  = lat_cfg;
                    ovr_op  = ovr_cfg;
                    tmo     = (lat_op == 0) || (lat_op > TO);
                    gnt_cyc = cyc + 1;
                    vld_cyc = gnt_cyc + (tmo ? TO : lat_op) + 1;
                    idle_from = vld_cyc + 1;
                    exp_err = tmo;
                    exp_res = tmo ? 32'h0 : (ovr_op ? 32'h1234 : 32'(op_a) * 32'(op_b));
                end
            end
            cyc++;
        end
    end

    task automatic wait_ev(input bit want_vld, output bit got, output bit who);
        got = 0;
        who = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (want_vld ? (vld0 | vld1) : (gnt0 | gnt1)) begin
                got = 1;
                who = want_vld ? vld1 : gnt1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_%s: got no pulse expected one within 40 cycles", want_vld ? "vld" : "gnt");
        end
    endtask

    typedef struct {
        bit            r0, r1;
        logic [DW-1:0] a0, b0, a1, b1;
        int            lat;
        bit            ovr;
        bit            own;
        logic [31:0]   res;
        bit            err;
        int            dly;
    } vec_t;

    task automatic run_op(input vec_t v, input string nm);
        bit got, who;
        int n;
        @(posedge clk); #1;
        req0 = v.r0; a0 = v.a0; b0 = v.b0;
        req1 = v.r1; a1 = v.a1; b1 = v.b1;
        lat_cfg = v.lat; ovr_cfg = v.ovr;
        wait_ev(0, got, who);
        if (got) chk({nm, "_gnt_owner"}, who, v.own);
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        n = 0;
        got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (vld0 | vld1) begin got = 1; n = k; break; end
        end
        chk({nm, "_vld_seen"}, got, 1);
        if (got) begin
            chk({nm, "_vld_delay"}, n, v.dly);
            chk({nm, "_vld_owner"}, vld1, v.own);
            chk({nm, "_res"}, res, v.res);
            chk({nm, "_err"}, err, v.err);
        end
    endtask

    vec_t tbl[9];
    initial begin
        bit got, who;
        int nv;
        //          r0 r1  a0       b0       a1       b1       lat ovr own res            err dly
        tbl[0] = '{1, 0, 16'd3,    16'd5,   16'd0,   16'd0,   4,  0,  0, 32'd15,        0,  5};
        tbl[1] = '{0, 1, 16'd0,    16'd0,   16'd6,   16'd6,   2,  0,  1, 32'd36,        0,  3};
        tbl[2] = '{1, 1, 16'd2,    16'd7,   16'd4,   16'd9,   3,  0,  0, 32'd14,        0,  4};
        tbl[3] = '{1, 1, 16'd2,    16'd7,   16'd4,   16'd9,   3,  0,  1, 32'd36,        0,  4};
        tbl[4] = '{1, 0, 16'd9,    16'd9,   16'd0,   16'd0,   0,  0,  0, 32'd0,         1,  16};
        tbl[5] = '{0, 1, 16'd0,    16'd0,   16'h0101, 16'd2,  15, 1,  1, 32'h1234,      0,  16};
        tbl[6] = '{1, 0, 16'd7,    16'd7,   16'd0,   16'd0,   16, 0,  0, 32'd0,         1,  16};
        tbl[7] = '{0, 1, 16'd0,    16'd0,   16'hFFFF, 16'hFFFF, 1, 0, 1, 32'hFFFE0001,  0,  2};
        tbl[8] = '{1, 1, 16'h8000, 16'd2,   16'd1,   16'd1,   5,  0,  0, 32'h00010000,  0,  6};

        reset = 1; req0 = 1; req1 = 1;
        a0 = 16'd2; b0 = 16'd7; a1 = 16'd4; b1 = 16'd9;
        lat_cfg = 3; ovr_cfg = 0;

        // Reset held two cycles with both requests pending.
        @(posedge clk);
        mon_en = 1;
        @(negedge clk);
        chk("reset_ctl", {gnt0, gnt1, vld0, vld1, err, mul_start}, 6'b0);
        chk("reset_data", {res, mul_a, mul_b}, 64'h0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("reset_ctl2", {gnt0, gnt1, vld0, vld1, err, mul_start}, 6'b0);
        chk("reset_data2", {res, mul_a, mul_b}, 64'h0);

        // Held contention: grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++) begin
            wait_ev(0, got, who);
            if (got) chk($sformatf("cont_gnt%0d", i), who, i % 2);
            wait_ev(1, got, who);
            if (got) begin
                chk($sformatf("cont_vld%0d", i), who, i % 2);
                chk($sformatf("cont_res%0d", i), res, (i % 2) ? 32'd36 : 32'd14);
            end
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting on the multiplier; its late done must be dropped.
        @(posedge clk); #1;
        req0 = 1; a0 = 16'd5; b0 = 16'd5; lat_cfg = 10;
        wait_ev(0, got, who);
        @(posedge clk); #1;
        req0 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vld0 | vld1) nv++;
        end
        chk("no_vld_after_reset", nv, 0);
        run_op('{0, 1, 16'd0, 16'd0, 16'd6, 16'd6, 3, 0, 1, 32'd36, 0, 4}, "post_reset");

        // Random traffic; operands only change while idle or on the grant cycle.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!req0 || gnt0) begin
                req0 = ($urandom_range(0, 2) != 0);
                a0 = 16'($urandom); b0 = 16'($urandom);
            end
            if (!req1 || gnt1) begin
                req1 = ($urandom_range(0, 2) != 0);
                a1 = 16'($urandom); b1 = 16'($urandom);
            end
            lat_cfg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(1, 6));
            ovr_cfg = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        repeat (30) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not end in time");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle multiplier between two requesters.
- Captures the granted requester's operands, starts the multiplier, and waits for its done pulse or a watchdog timeout.
- Returns the product, with a valid pulse and error flag, to the requester that issued it.
- Sits between two operand sources (e.g. FIFO read-side logic) and the multiplier core.

Parameters:
DW, 16, operand width; product width is 2*DW
TIMEOUT, 15, maximum WAIT cycles before declaring a hung multiplier (1..2^TW-1)
TW, 4, watchdog counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 operation request
a0  input  DW  requester 0 operand A
b0  input  DW  requester 0 operand B
req1  input  1  requester 1 operation request
a1  input  DW  requester 1 operand A
b1  input  DW  requester 1 operand B
gnt0  output  1  one-cycle pulse: requester 0 operands captured
gnt1  output  1  one-cycle pulse: requester 1 operands captured
vld0  output  1  one-cycle pulse: result for requester 0 on res/err
vld1  output  1  one-cycle pulse: result for requester 1 on res/err
res  output  2*DW  returned product
err  output  1  result invalid (timeout); qualified by vld0/vld1
mul_start  output  1  one-cycle start pulse to multiplier
mul_a  output  DW  multiplier operand A
mul_b  output  DW  multiplier operand B
mul_done  input  1  multiplier completion pulse
mul_result  input  2*DW  multiplier product, valid with mul_done

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - gnt0/1, vld0/1, mul_start, err = 0; res, mul_a, mul_b = 0.
  - State = IDLE; watchdog = 0; last_grant = 1, so requester 0 wins first.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - With no requests, stay in IDLE.
  - With exactly one request, select that requester.
  - With both requests, select the requester that is not last_grant.
  - On selection: the next cycle enters ISSUE with gnt_x=1, mul_start=1, and mul_a/mul_b loaded from the selected a_x/b_x.
- Requester rules:
  - Operands must stay stable while req is high and gnt is low.
  - Operands are captured exactly at the gnt pulse.
  - A requester that keeps req high after gnt queues a further operation.
- ISSUE:
  - Lasts one cycle with gnt_x and mul_start high, then goes to WAIT.
  - Watchdog clears to 0.
- WAIT:
  - Watchdog increments each cycle.
  - If mul_done=1: res <= mul_result, err <= 0, go to RESP.
  - Else if watchdog==TIMEOUT-1, meaning this is the TIMEOUT-th WAIT cycle: res <= 0, err <= 1, go to RESP.
  - If mul_done and the timeout fall in the same cycle, mul_done wins (err=0).
- RESP:
  - Lasts one cycle with vld_x=1 for the owning requester; last_grant <= owner; then IDLE.
  - res holds its value until the next RESP.
  - err is meaningful only while a vld is high.
- Latency:
  - req sampled high in IDLE at cycle n gives gnt at n+1.
  - mul_done at cycle m gives vld at m+1.
  - Back-to-back grants are at least 4 cycles apart (IDLE, ISSUE, WAIT, RESP).
- mul_done in IDLE, ISSUE or RESP is ignored.
- Dropping req after gnt does not cancel the operation; vld is still delivered.
- mul_a/mul_b hold their values until the next grant.
- Reset during any state, including WAIT:
  - Return to IDLE with reset values; the in-flight result is discarded.
  - No vld is issued.
  - A late mul_done is ignored.
- Widths: res is exactly 2*DW bits, passed through unmodified; the block does no arithmetic.

Test Plan:
- Reset: assert reset 2 cycles with req0=req1=1 -> all outputs 0, no gnt while reset high; first gnt after release is gnt0.
- Single op: req0=1, a0=3, b0=5; model returns mul_done 4 cycles after mul_start with mul_result=15 -> gnt0 and mul_start at n+1 with mul_a=3, mul_b=5; vld0=1, res=15, err=0 one cycle after done; vld1 never asserts.
- Contention: req0=req1=1 held, a0=2,b0=7, a1=4,b1=9 -> grant order 0,1,0,1; res sequence 14,36,14,36 with matching vld0/vld1.
- Timeout: mul_done never asserted, TIMEOUT=15 -> vld pulse exactly 15 WAIT cycles after ISSUE with err=1, res=0; next request proceeds normally.
- Simultaneous: mul_done on the 15th WAIT cycle with mul_result=0x1234 -> err=0, res=0x1234.
- Reset mid-op: reset during WAIT, then mul_done pulses -> no vld, state IDLE; a new req1 (a1=6, b1=6) is granted and returns res=36.
